// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 4-stage IEEE-754-style multiplier with RNE, DAZ/FTZ, valid/ready backpressure; ports clk rst in_valid in_ready a b out_valid out_ready result overflow underflow invalid inexact
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid,
  output logic         inexact
);
  localparam int M = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0] INF = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
  logic adv;
  logic [EXP_W-1:0] ea, eb, ea1, eb1;
  logic [MAN_W-1:0] fa, fb, f3, fr;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [2:0] cls, c1, c2, c3;
  logic v1, v2, v3, s1, s2, s3;
  logic [M-1:0] ma1, mb1;
  logic signed [EW-1:0] e2, e3, er;
  logic [2*M-1:0] p2, n;
  logic g3, st3, inc, carry, ovf_r, unf_r, spec;
  logic [W-1:0] res;
  logic ovf, unf, inx;
  assign adv = !out_valid | out_ready;
  assign in_ready = adv;
  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_inf = &ea & ~|fa;
  assign b_inf = &eb & ~|fb;
  assign a_nan = &ea & |fa;
  assign b_nan = &eb & |fb;
  assign cls = {a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf), a_inf | b_inf, a_zero | b_zero};
  assign n = p2[2*M-1] ? p2 : p2 << 1;
  assign inc = g3 & (st3 | f3[0]);
  assign {carry, fr} = {1'b0, f3} + (MAN_W+1)'(inc);
  assign er = e3 + EW'(carry);
  assign ovf_r = ~er[EW-1] & (er[EW-2:0] >= EMAX);
  assign unf_r = er[EW-1] | ~|er;
  assign spec = |c3;
  assign res = c3[2] ? QNAN :
               c3[1] ? {s3, INF} :
               c3[0] ? {s3, {(W-1){1'b0}}} :
               ovf_r ? {s3, INF} :
               unf_r ? {s3, {(W-1){1'b0}}} :
               {s3, er[EXP_W-1:0], fr};
  assign ovf = !spec & ovf_r;
  assign unf = !spec & !ovf_r & unf_r;
  assign inx = !spec & (ovf_r | unf_r | g3 | st3);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, v2, v3, s1, s2, s3, c1, c2, c3} <= '0;
      {ea1, eb1, ma1, mb1, e2, p2, e3, f3, g3, st3} <= '0;
      {out_valid, result, overflow, underflow, invalid, inexact} <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      s1 <= a[W-1] ^ b[W-1];
      c1 <= cls;
      ea1 <= ea;
      eb1 <= eb;
      ma1 <= {1'b1, fa};
      mb1 <= {1'b1, fb};
      v2 <= v1;
      s2 <= s1;
      c2 <= c1;
      e2 <= {2'b0, ea1} + {2'b0, eb1} - EW'(BIAS);
      p2 <= (2*M)'(ma1) * (2*M)'(mb1);
      v3 <= v2;
      s3 <= s2;
      c3 <= c2;
      e3 <= e2 + EW'(p2[2*M-1]);
      f3 <= n[2*M-2 -: MAN_W];
      g3 <= n[MAN_W];
      st3 <= |n[MAN_W-1:0];
      out_valid <= v3;
      result <= res;
      overflow <= ovf;
      underflow <= unf;
      invalid <= c3[2];
      inexact <= inx;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: self-checking bench for fp_mul_pipe (binary32 plus a binary16 instance) against an arithmetic reference model
module tb_fp_mul_pipe;
  logic clk = 0, rst;
  logic in_valid, in_ready, out_valid, out_ready, overflow, underflow, invalid, inexact;
  logic [31:0] a, b, result;
  logic h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_ovf, h_unf, h_inv, h_inx;
  logic [15:0] h_a, h_b, h_result;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid), .inexact(inexact)
  );
  fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .result(h_result),
    .overflow(h_ovf), .underflow(h_unf), .invalid(h_inv), .inexact(h_inx)
  );
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e;
    logic [22:0] fx, fy;
    logic s, inx;
    logic [63:0] m, q, rem, half;
    int sh;
    bit xz, yz, xi, yi, xn, yn;
    ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0]; s = x[31] ^ y[31];
    xz = ex == 0; yz = ey == 0;
    xi = ex == 255 && fx == 0; yi = ey == 255 && fy == 0;
    xn = ex == 255 && fx != 0; yn = ey == 255 && fy != 0;
    if (xn || yn || (xi && yz) || (xz && yi)) return {4'b0010, 32'h7FC00000};
    if (xi || yi) return {4'b0000, s, 8'hFF, 23'h0};
    if (xz || yz) return {4'b0000, s, 31'h0};
    m = (64'(fx) | 64'h800000) * (64'(fy) | 64'h800000);
    e = ex + ey - 127;
    sh = 23;
    if (m >= (64'd1 << 47)) begin sh = 24; e++; end
    q = m >> sh;
    rem = m - (q << sh);
    half = 64'd1 << (sh - 1);
    inx = rem != 0;
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    if (e >= 255) return {4'b1001, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0101, s, 31'h0};
    return {3'b000, inx, s, 8'(e), q[22:0]};
  endfunction
  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 9);
    f = 23'($urandom);
    if ($urandom_range(0, 3) == 0) f = f & 23'h000FFF;
    e = k == 0 ? 8'h00 : k == 1 ? 8'hFF : k == 2 ? 8'($urandom_range(190, 254)) :
        k == 3 ? 8'($urandom_range(1, 64)) : 8'($urandom_range(100, 154));
    if (k == 1 && $urandom_range(0, 1) == 1) f = '0;
    return {1'($urandom), e, f};
  endfunction
  function automatic logic [31:0] norm_op();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    a = x; b = y; in_valid = 1; out_ready = 1; lat = -1; r = 'x; f = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 0;
      if (out_valid) begin
        lat = i; r = result; f = {overflow, underflow, invalid, inexact};
        break;
      end
    end
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0; a = '0; b = '0;
    h_in_valid = 0; h_out_ready = 0; h_a = '0; h_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passed++;
    checks++; if ({overflow, underflow, invalid, inexact} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {overflow, underflow, invalid, inexact}); else passed++;
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (h_out_valid !== 1'b0) $display("FAIL reset_h_out_valid: got %b want 0", h_out_valid); else passed++;
  endtask
  task automatic test_latency();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    run_op(32'h3FC00000, 32'h40000000, r, f, lat);
    checks++; if (lat !== 4) $display("FAIL latency: got %0d want 4", lat); else passed++;
    checks++; if (r !== 32'h40400000) $display("FAIL latency_result: got %h want 40400000", r); else passed++;
    checks++; if (f !== 4'b0) $display("FAIL latency_flags: got %b want 0000", f); else passed++;
  endtask
  task automatic test_directed();
    logic [31:0] ta[10] = '{32'h3F800001, 32'h3F800800, 32'h7F000000, 32'h00800000, 32'h80000000,
                            32'h7F800000, 32'hFF800000, 32'h7FA00000, 32'hFF800000, 32'h3F800000};
    logic [31:0] tb[10] = '{32'h3F800001, 32'h3F800800, 32'h7F000000, 32'h00800000, 32'h3F800000,
                            32'h00000000, 32'h40000000, 32'h3F800000, 32'h80000000, 32'h7FA00000};
    logic [31:0] tr[10] = '{32'h3F800002, 32'h3F801000, 32'h7F800000, 32'h00000000, 32'h80000000,
                            32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000};
    logic [3:0] tf[10] = '{4'b0001, 4'b0001, 4'b1001, 4'b0101, 4'b0000,
                           4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], r, f, lat);
      checks++; if (r !== tr[i]) $display("FAIL directed_result[%0d]: %h*%h got %h want %h", i, ta[i], tb[i], r, tr[i]); else passed++;
      checks++; if (f !== tf[i]) $display("FAIL directed_flags[%0d]: got %b want %b", i, f, tf[i]); else passed++;
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] oa[6], ob[6];
    logic [35:0] held, exp0;
    int acc = 0, got = 0;
    bit seen = 0, dup = 0;
    for (int i = 0; i < 6; i++) begin oa[i] = norm_op(); ob[i] = norm_op(); end
    exp0 = model(oa[0], ob[0]);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 0;
      in_valid = acc < 6;
      if (acc < 6) begin a = oa[acc]; b = ob[acc]; end
      #1;
      if (out_valid && !seen) begin seen = 1; held = {overflow, underflow, invalid, inexact, result}; end
      if (in_valid && in_ready) acc++;
    end
    checks++; if (acc !== 4) $display("FAIL bp_accepted: got %0d want 4", acc); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else passed++;
    checks++; if (!seen || {overflow, underflow, invalid, inexact, result} !== held) $display("FAIL bp_hold: got %h want %h", {overflow, underflow, invalid, inexact, result}, held); else passed++;
    checks++; if (held !== exp0) $display("FAIL bp_head: got %h want %h", held, exp0); else passed++;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = 1;
      in_valid = acc < 6;
      if (acc < 6) begin a = oa[acc]; b = ob[acc]; end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if ({overflow, underflow, invalid, inexact, result} !== model(oa[got], ob[got]))
          $display("FAIL bp_order[%0d]: got %h want %h", got, {overflow, underflow, invalid, inexact, result}, model(oa[got], ob[got]));
        else passed++;
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 0;
    checks++; if (got !== 6) $display("FAIL bp_drained: got %0d want 6", got); else passed++;
    repeat (6) begin @(negedge clk); if (out_valid) dup = 1; end
    checks++; if (dup) $display("FAIL bp_duplicate: got extra out_valid want none"); else passed++;
  endtask
  task automatic test_reset_mid();
    logic [31:0] x, y, r;
    logic [3:0] f;
    logic [35:0] e;
    int lat;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); in_valid = 1; a = norm_op(); b = norm_op(); end
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_inflight: got %b want 1", out_valid); else passed++;
    rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h want 0", result); else passed++;
    checks++; if ({overflow, underflow, invalid, inexact} !== 4'b0) $display("FAIL rstmid_flags: got %b want 0000", {overflow, underflow, invalid, inexact}); else passed++;
    @(negedge clk);
    rst = 0;
    x = norm_op(); y = norm_op(); e = model(x, y);
    run_op(x, y, r, f, lat);
    checks++; if (lat !== 4) $display("FAIL rstmid_latency: got %0d want 4", lat); else passed++;
    checks++; if ({f, r} !== e) $display("FAIL rstmid_value: got %h want %h", {f, r}, e); else passed++;
  endtask
  task automatic test_random();
    logic [35:0] sb[$];
    logic [35:0] held, exp_v, obs;
    bit hold = 0;
    int sent = 0, got = 0, cyc = 0;
    localparam int N = 10000;
    while (got < N && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      obs = {overflow, underflow, invalid, inexact, result};
      if (hold) begin
        checks++;
        if (!out_valid || obs !== held) $display("FAIL rand_stall_hold: got %b/%h want 1/%h", out_valid, obs, held);
        else passed++;
      end
      in_valid = sent < N && $urandom_range(0, 3) != 0;
      if (in_valid) begin a = rand_op(); b = rand_op(); end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) $display("FAIL rand_spurious: got %h want no output", obs);
        else begin
          exp_v = sb.pop_front();
          if (obs !== exp_v) $display("FAIL rand_result[%0d]: got %h want %h", got, obs, exp_v);
          else passed++;
        end
        got++;
      end
      if (in_valid && in_ready) begin sb.push_back(model(a, b)); sent++; end
      hold = out_valid && !out_ready;
      held = obs;
    end
    in_valid = 0;
    out_ready = 1;
    checks++; if (got !== N) $display("FAIL rand_count: got %0d want %0d", got, N); else passed++;
  endtask
  task automatic test_half();
    int lat = -1;
    @(negedge clk);
    h_a = 16'h3E00; h_b = 16'h4000; h_in_valid = 1; h_out_ready = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      h_in_valid = 0;
      if (h_out_valid) begin lat = i; break; end
    end
    checks++; if (lat !== 4) $display("FAIL half_latency: got %0d want 4", lat); else passed++;
    checks++; if (h_result !== 16'h4200) $display("FAIL half_result: got %h want 4200", h_result); else passed++;
    checks++; if ({h_ovf, h_unf, h_inv, h_inx} !== 4'b0) $display("FAIL half_flags: got %b want 0000", {h_ovf, h_unf, h_inv, h_inx}); else passed++;
  endtask
  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_half();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised IEEE-754-style floating-point multiplier with a 4-stage pipeline.
- Supports configurable exponent and mantissa widths, valid/ready handshaking on both sides with full backpressure, round-to-nearest-even, and special-value handling (zero, inf, NaN).
- Subnormal inputs are treated as zero; subnormal results are flushed to zero.
- Next-generation drop-in for the datapath multiplier slot; default parameters give binary32.

Parameters:
- EXP_W, 8: exponent field width (min 4); BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width (min 4); total word W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- a  in  W  operand A, {sign, exp, frac}.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  product.
- overflow  out  1  result overflowed to inf.
- underflow  out  1  nonzero product flushed to zero.
- invalid  out  1  NaN operand or inf*0.
- inexact  out  1  rounding or flushing lost bits.

Behaviour:
- Reset:
  - All stage valid bits, result and flags go to 0; out_valid=0.
  - Asserting rst mid-operation discards every in-flight operation; nothing is replayed.
- Pipeline advance:
  - adv = !out_valid | out_ready; in_ready = adv (combinational from out_ready).
  - When adv=0, every stage holds, including bubbles; result and flags stay stable while out_valid=1 and out_ready=0.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency and throughput:
  - An operand accepted at edge k produces out_valid=1 after edge k+4, with no stall.
  - Throughput is 1 per cycle; capacity is 4 operations; order is preserved.
- S1, decode:
  - Classify each operand: zero (exp=0, including subnormals, DAZ), inf (exp=all-ones, frac=0), NaN (exp=all-ones, frac!=0).
  - Significand = {1, frac}.
  - sign = sa^sb.
- S2, multiply:
  - P = ma*mb, width 2*(MAN_W+1).
  - E = ea+eb-BIAS, computed signed with EXP_W+2 bits.
- S3, normalise:
  - If P MSB=1, take P[top-1 -: MAN_W] and set E+=1; otherwise shift by one.
  - guard = next bit below the kept fraction; sticky = OR of all lower bits.
- S4, round and pack:
  - RNE: increment when guard & (sticky | lsb).
  - Fraction carry-out sets E+=1 with fraction=0.
  - inexact = guard | sticky.
- Special-case priority, evaluated in S4 using classes carried from S1:
  1. Either operand NaN, or inf*zero: result = canonical qNaN {0, all-ones, 1, 0...}, invalid=1, other flags 0.
  2. Either operand inf: result = {sign, all-ones, 0}, no flags.
  3. Either operand zero: result = {sign, 0...}, no flags.
  4. E >= 2^EXP_W-1 after rounding: result = {sign, inf}, overflow=1, inexact=1.
  5. E <= 0: result = {sign, 0...}, underflow=1, inexact=1. There is no subnormal output.
  6. Otherwise: {sign, E[EXP_W-1:0], rounded fraction}.
- Flags qualify only when out_valid=1; they reset to 0 and are not sticky.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0), in_valid for one cycle, out_ready=1 -> out_valid exactly 4 cycles later; result=0x40400000, all flags 0.
- Rounding cases:
  - 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1.
  - Tie case 0x3F800800 * 0x3F800800 -> 0x3F801000 (tie to even), inexact=1.
- Range limits:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1, inexact=1.
  - 0x00800000 * 0x00800000 -> 0x00000000, underflow=1, inexact=1.
  - 0x80000000 * 0x3F800000 -> 0x80000000, no flags.
- Special values:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 * 0x40000000 -> 0xFF800000, no flags.
  - 0x7FA00000 * 0x3F800000 -> 0x7FC00000, invalid=1.
- Backpressure:
  - Stream 6 back-to-back operands with out_ready=0: exactly 4 accepted, then in_ready=0; result is held stable.
  - Release out_ready: all 6 emerge in order, none lost or duplicated.
  - Randomised in_valid/out_ready against a reference model for 10k ops.
- Reset mid-stream:
  - Assert rst with 3 ops in flight -> out_valid=0 immediately (async), outputs 0.
  - After release, the first new op emerges 4 cycles after acceptance with the correct value.
  - Also run with EXP_W=5, MAN_W=10: 0x3E00 * 0x4000 -> 0x4200.
